// File: rtl/cog_hub_port.sv
// Cog-side hub bus initiator: one hub transaction per cog request, with select-gated bus outputs.
// Optional ack timeout enabled by defining COG_HUB_TIMEOUT_EN.
module cog_hub_port #(
    parameter int TIMEOUT_W = 6
) (
    input  logic        clk_cog,
    input  logic        nres,
    input  logic        ena_bus,
    input  logic        req,
    input  logic        op_w,
    input  logic [1:0]  op_s,
    input  logic [15:0] op_a,
    input  logic [31:0] op_d,
    input  logic        run,
    output logic        busy,
    output logic        done,
    output logic [31:0] res_q,
    output logic        res_c,
    output logic        err,
    input  logic        bus_sel_n,
    output logic        bus_r,
    output logic        bus_e,
    output logic        bus_w,
    output logic [1:0]  bus_s,
    output logic [15:0] bus_a,
    output logic [31:0] bus_d,
    input  logic        bus_ack,
    input  logic [31:0] bus_q,
    input  logic        bus_c
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic        hold_w_q;
    logic [1:0]  hold_s_q;
    logic [15:0] hold_a_q;
    logic [31:0] hold_d_q;
    logic        run_q;
    logic [31:0] resq_q;
    logic        resc_q;

    logic in_req;
    logic accept;
    logic ack_ok;
    logic tmo;
    logic gate;

    assign in_req = (state_q == REQ);
    assign accept = (state_q == IDLE) & req;
    assign ack_ok = in_req & ena_bus & bus_ack;

`ifdef COG_HUB_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] CNT_LAST = {TIMEOUT_W{1'b1}} - TIMEOUT_W'(1);

    logic [TIMEOUT_W-1:0] cnt_q;
    logic                 err_q;

    // Terminal count is reached on the slot that would make the counter all-ones.
    assign tmo = in_req & ena_bus & ~bus_ack & (cnt_q == CNT_LAST);

    always_ff @(posedge clk_cog or negedge nres) begin
        if (!nres) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (accept) begin
                cnt_q <= '0;
            end else if (in_req && ena_bus) begin
                cnt_q <= cnt_q + TIMEOUT_W'(1);
            end
            if (ack_ok) begin
                err_q <= 1'b0;
            end else if (tmo) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign tmo = 1'b0;
    assign err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req) state_d = REQ;
            REQ:     if (ack_ok || tmo) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_cog or negedge nres) begin
        if (!nres) begin
            state_q <= IDLE;
            resq_q  <= '0;
            resc_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (ack_ok) begin
                resq_q <= bus_q;
                resc_q <= bus_c;
            end else if (tmo) begin
                resq_q <= '0;
                resc_q <= 1'b0;
            end
        end
    end

    // Holding registers need no reset: they are only visible through the REQ gate.
    always_ff @(posedge clk_cog) begin
        if (accept) begin
            hold_w_q <= op_w;
            hold_s_q <= op_s;
            hold_a_q <= op_a;
            hold_d_q <= op_d;
            run_q    <= run;
        end
    end

    assign gate  = bus_sel_n & in_req;
    assign bus_e = gate;
    assign bus_r = gate & run_q;
    assign bus_w = gate & hold_w_q;
    assign bus_s = {2{gate}} & hold_s_q;
    assign bus_a = {16{gate}} & hold_a_q;
    assign bus_d = {32{gate}} & hold_d_q;

    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);
    assign res_q = resq_q;
    assign res_c = resc_q;

endmodule
